router_cfg_ahb_master: RTL and testbench



---
 rtl/router_cfg_ahb_master.sv | 162 ++++++++++++++++
 tb/tb_router_cfg_ahb_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_cfg_ahb_master.sv
// Single-outstanding AHB-Lite master: turns a valid/ready command stream into
// AHB single word transfers and returns status on a valid/ready response channel.
module router_cfg_ahb_master #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int TMO_CYCLES = 255
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [AWIDTH-1:0] i_cmd_addr,
    input  logic [DWIDTH-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DWIDTH-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    output logic              o_rsp_timeout,
    output logic [AWIDTH-1:0] o_haddr,
    output logic              o_hwrite,
    output logic              o_hsel,
    output logic [DWIDTH-1:0] o_hwdata,
    output logic [1:0]        o_htrans,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    output logic              o_hreadyin,
    input  logic              i_hready,
    input  logic [DWIDTH-1:0] i_hrdata,
    input  logic [1:0]        i_hresp,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LIMIT    = 16'(TMO_CYCLES);
    localparam logic [1:0]  HTRANS_IDLE  = 2'b00;
    localparam logic [1:0]  HTRANS_NSEQ  = 2'b10;

    state_t            state, state_nxt;
    logic [15:0]       cnt_q, cnt_nxt;
    logic              write_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              accept;
    logic              rsp_load;
    logic [DWIDTH-1:0] rdata_nxt;
    logic              err_nxt;
    logic              tmo_nxt;

    assign accept     = o_cmd_ready & i_cmd_valid;
    assign o_hsize    = 3'b010;
    assign o_hburst   = 3'b000;
    assign o_hreadyin = i_hready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        rsp_load  = 1'b0;
        rdata_nxt = '0;
        err_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (i_cmd_addr[1:0] != 2'b00) begin
                        // misaligned: answer with an error without touching the bus
                        state_nxt = ST_RESP;
                        rsp_load  = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (i_hready) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (i_hready) begin
                    state_nxt = ST_RESP;
                    rsp_load  = 1'b1;
                    if (i_hresp[0]) begin
                        err_nxt = 1'b1;
                    end else if (!write_q) begin
                        rdata_nxt = i_hrdata;
                    end
                end else if (cnt_q == TMO_LIMIT) begin
                    state_nxt = ST_RESP;
                    rsp_load  = 1'b1;
                    err_nxt   = 1'b1;
                    tmo_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            state         <= ST_IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            o_cmd_ready   <= 1'b0;
            o_busy        <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_error   <= 1'b0;
            o_rsp_timeout <= 1'b0;
            o_haddr       <= '0;
            o_hwrite      <= 1'b0;
            o_hsel        <= 1'b0;
            o_hwdata      <= '0;
            o_htrans      <= HTRANS_IDLE;
        end else begin
            state       <= state_nxt;
            cnt_q       <= cnt_nxt;
            o_cmd_ready <= (state_nxt == ST_IDLE);
            o_busy      <= (state_nxt != ST_IDLE);
            o_rsp_valid <= (state_nxt == ST_RESP);
            o_hsel      <= (state_nxt == ST_ADDR);
            o_htrans    <= (state_nxt == ST_ADDR) ? HTRANS_NSEQ : HTRANS_IDLE;
            if (accept) begin
                write_q <= i_cmd_write;
                wdata_q <= i_cmd_wdata;
            end
            if (state == ST_IDLE && state_nxt == ST_ADDR) begin
                o_haddr  <= i_cmd_addr;
                o_hwrite <= i_cmd_write;
            end
            if (state == ST_ADDR && state_nxt == ST_DATA) begin
                o_hwdata <= wdata_q;
            end
            if (rsp_load) begin
                o_rsp_rdata   <= rdata_nxt;
                o_rsp_error   <= err_nxt;
                o_rsp_timeout <= tmo_nxt;
            end else if (state == ST_RESP && state_nxt == ST_IDLE) begin
                o_rsp_rdata   <= '0;
                o_rsp_error   <= 1'b0;
                o_rsp_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_cfg_ahb_master.sv
// Directed bench for router_cfg_ahb_master: expected responses are queued at
// command issue and compared when the master presents its response.
module tb_router_cfg_ahb_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic          i_hclk;
    logic          i_hreset;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_error;
    logic          o_rsp_timeout;
    logic [AW-1:0] o_haddr;
    logic          o_hwrite;
    logic          o_hsel;
    logic [DW-1:0] o_hwdata;
    logic [1:0]    o_htrans;
    logic [2:0]    o_hsize;
    logic [2:0]    o_hburst;
    logic          o_hreadyin;
    logic          i_hready;
    logic [DW-1:0] i_hrdata;
    logic [1:0]    i_hresp;
    logic          o_busy;

    rsp_t sb[$];
    int   n_cmp     = 0;
    int   n_mis     = 0;
    int   since_acc = 0;

    router_cfg_ahb_master #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .TMO_CYCLES(TMO)
    ) dut (
        .i_hclk       (i_hclk),
        .i_hreset     (i_hreset),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_write  (i_cmd_write),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_wdata  (i_cmd_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_error  (o_rsp_error),
        .o_rsp_timeout(o_rsp_timeout),
        .o_haddr      (o_haddr),
        .o_hwrite     (o_hwrite),
        .o_hsel       (o_hsel),
        .o_hwdata     (o_hwdata),
        .o_htrans     (o_htrans),
        .o_hsize      (o_hsize),
        .o_hburst     (o_hburst),
        .o_hreadyin   (o_hreadyin),
        .i_hready     (i_hready),
        .i_hrdata     (i_hrdata),
        .i_hresp      (i_hresp),
        .o_busy       (o_busy)
    );

    initial i_hclk = 1'b0;
    always #5 i_hclk = ~i_hclk;

    task automatic tick();
        @(negedge i_hclk);
        since_acc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command at a negedge; returns in the cycle after acceptance.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input rsp_t exp);
        chk("cmd_ready_before_send", {63'd0, o_cmd_ready}, 64'd1);
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = addr;
        i_cmd_wdata = wd;
        sb.push_back(exp);
        @(negedge i_hclk);
        since_acc   = 1;
        i_cmd_valid = 1'b0;
        i_cmd_addr  = 32'hFFFF_FFF0;
        i_cmd_wdata = 32'h0BAD_0BAD;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        rsp_t e;
        while (o_rsp_valid !== 1'b1 && since_acc < 40) tick();
        chk({tag, "_latency"}, 64'(since_acc), 64'(exp_lat));
        chk({tag, "_sb_nonempty"}, {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"},   64'(o_rsp_rdata),   64'(e.rdata));
            chk({tag, "_error"},   {63'd0, o_rsp_error},   {63'd0, e.err});
            chk({tag, "_timeout"}, {63'd0, o_rsp_timeout}, {63'd0, e.tmo});
        end
    endtask

    task automatic back_to_idle(input string tag);
        tick();
        chk({tag, "_idle_ready"}, {63'd0, o_cmd_ready}, 64'd1);
        chk({tag, "_idle_rsp_valid"}, {63'd0, o_rsp_valid}, 64'd0);
        chk({tag, "_idle_busy"}, {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        i_hreset    = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_write = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_wdata = '0;
        i_rsp_ready = 1'b1;
        i_hready    = 1'b1;
        i_hrdata    = '0;
        i_hresp     = 2'b00;

        // reset state
        repeat (2) @(negedge i_hclk);
        chk("rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
        chk("rst_htrans",    64'(o_htrans), 64'd0);
        chk("rst_hsel",      {63'd0, o_hsel}, 64'd0);
        chk("rst_busy",      {63'd0, o_busy}, 64'd0);
        chk("hsize",         64'(o_hsize), 64'd2);
        chk("hburst",        64'(o_hburst), 64'd0);
        i_hreset = 1'b1;
        tick();
        chk("post_rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);

        // zero-wait write of 0xDEADBEEF to 0x4
        send(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
        chk("wr_addr_htrans", 64'(o_htrans), 64'd2);
        chk("wr_addr_hsel",   {63'd0, o_hsel}, 64'd1);
        chk("wr_addr_haddr",  64'(o_haddr), 64'h4);
        chk("wr_addr_hwrite", {63'd0, o_hwrite}, 64'd1);
        chk("wr_addr_ready",  {63'd0, o_cmd_ready}, 64'd0);
        chk("hreadyin_pass",  {63'd0, o_hreadyin}, 64'd1);
        tick();
        chk("wr_data_htrans", 64'(o_htrans), 64'd0);
        chk("wr_data_hsel",   {63'd0, o_hsel}, 64'd0);
        chk("wr_data_hwdata", 64'(o_hwdata), 64'hDEAD_BEEF);
        wait_rsp("wr_zero_wait", 3);
        back_to_idle("wr_zero_wait");

        // zero-wait read back from 0x4
        i_hrdata = 32'hDEAD_BEEF;
        send(1'b0, 32'h0000_0004, 32'h0, '{rdata: 32'hDEAD_BEEF, err: 1'b0, tmo: 1'b0});
        chk("rd_addr_hwrite", {63'd0, o_hwrite}, 64'd0);
        wait_rsp("rd_zero_wait", 3);
        back_to_idle("rd_zero_wait");

        // read with three data-phase wait states; junk rdata while waiting
        send(1'b0, 32'h0000_0008, 32'h0, '{rdata: 32'hCAFE_F00D, err: 1'b0, tmo: 1'b0});
        tick();
        i_hready = 1'b0;
        i_hrdata = 32'h1111_1111;
        chk("hreadyin_low", {63'd0, o_hreadyin}, 64'd0);
        repeat (3) tick();
        i_hready = 1'b1;
        i_hrdata = 32'hCAFE_F00D;
        chk("rd_wait_no_early_rsp", {63'd0, o_rsp_valid}, 64'd0);
        tick();
        i_hrdata = 32'h2222_2222;
        wait_rsp("rd_3wait", 6);
        back_to_idle("rd_3wait");

        // two-cycle ERROR on a write, response held for 5 cycles
        i_rsp_ready = 1'b0;
        i_hrdata    = 32'h3333_3333;
        send(1'b1, 32'h0000_0010, 32'h1234_5678, '{rdata: 32'h0, err: 1'b1, tmo: 1'b0});
        tick();
        i_hready = 1'b0;
        i_hresp  = 2'b01;
        tick();
        i_hready = 1'b1;
        tick();
        i_hresp  = 2'b00;
        wait_rsp("wr_error", 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
            chk("hold_rsp_error", {63'd0, o_rsp_error}, 64'd1);
            chk("hold_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
            chk("hold_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
        end
        i_rsp_ready = 1'b1;
        back_to_idle("wr_error");

        // timeout: hready stuck low through the data phase
        send(1'b0, 32'h0000_0020, 32'h0, '{rdata: 32'h0, err: 1'b1, tmo: 1'b1});
        tick();
        i_hready = 1'b0;
        i_hrdata = 32'h4444_4444;
        tick();
        chk("tmo_not_early", {63'd0, o_rsp_valid}, 64'd0);
        wait_rsp("timeout", 2 + TMO + 1);
        i_hready = 1'b1;
        back_to_idle("timeout");

        // misaligned command never reaches the bus
        send(1'b1, 32'h0000_0006, 32'h5555_5555, '{rdata: 32'h0, err: 1'b1, tmo: 1'b0});
        chk("misalign_htrans", 64'(o_htrans), 64'd0);
        chk("misalign_hsel",   {63'd0, o_hsel}, 64'd0);
        wait_rsp("misalign", 1);
        back_to_idle("misalign");

        // asynchronous reset in the middle of a stalled data phase
        send(1'b1, 32'h0000_0030, 32'h6666_6666, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
        tick();
        i_hready = 1'b0;
        tick();
        chk("pre_rst_busy", {63'd0, o_busy}, 64'd1);
        #2 i_hreset = 1'b0;
        #1;
        sb.delete();
        chk("midrst_busy",      {63'd0, o_busy}, 64'd0);
        chk("midrst_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
        chk("midrst_htrans",    64'(o_htrans), 64'd0);
        chk("midrst_hsel",      {63'd0, o_hsel}, 64'd0);
        chk("midrst_haddr",     64'(o_haddr), 64'd0);
        chk("midrst_hwrite",    {63'd0, o_hwrite}, 64'd0);
        chk("midrst_hwdata",    64'(o_hwdata), 64'd0);
        chk("midrst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
        i_hready = 1'b1;
        @(negedge i_hclk);
        i_hreset = 1'b1;
        tick();
        chk("post_midrst_ready", {63'd0, o_cmd_ready}, 64'd1);
        chk("post_midrst_busy",  {63'd0, o_busy}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
